// File: rtl/candidate_mapper.sv
// candidate_mapper: sequential candidate selection.
// Eligible slots come from the candidate bitmap, minus the current slot and
// recently issued slots. They are compacted into a table in ascending slot
// order. One entry is picked using random_number mod eligible-count, computed
// by a bit-serial restoring divider.
// Optional feature macro: MAP_FALLBACK_EN. When it is defined and history
// exclusion leaves no eligible slot, the table is rebuilt from
// candidate_list with only cur_index removed.
module candidate_mapper #(
  parameter int BS    = 16,
  parameter int HIST  = 3,
  parameter int RND_W = $clog2(BS) + 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [0:BS-1]         candidate_list,
  input  logic [$clog2(BS)-1:0] cur_index,
  input  logic [RND_W-1:0]      random_number,
  input  logic                  hist_clear,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [$clog2(BS)-1:0] rsp_index,
  output logic                  rsp_empty,
  output logic [$clog2(BS):0]   rsp_count
);

  localparam int IDX_W = $clog2(BS);
  localparam int CNT_W = ($clog2(RND_W) > 0) ? $clog2(RND_W) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_MOD, S_RESP} state_t;

  state_t                       state, state_nxt;
  logic   [CNT_W-1:0]           mod_cnt;
  logic                         accept;
  logic                         mod_last;
  logic                         push;

  logic   [HIST-1:0]            hist_vld;
  logic   [HIST-1:0][IDX_W-1:0] hist_idx;

  logic   [BS-1:0]              elig_c;
  logic   [BS-1:0]              fb_c;
  logic   [BS-1:0]              elig_p0;
  logic   [RND_W-1:0]           rnd_p0;
`ifdef MAP_FALLBACK_EN
  logic   [BS-1:0]              fb_p0;
`endif

  logic   [BS-1:0]              load_mask;
  logic   [BS-1:0][IDX_W-1:0]   tbl_c;
  logic   [IDX_W:0]             load_cnt;
  logic   [BS-1:0][IDX_W-1:0]   tbl_p1;
  logic   [IDX_W:0]             rem_p1;
  logic   [IDX_W:0]             rem_next;

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  // The incoming remainder is always below the divisor (<= BS), so its MSB is zero.
  function automatic logic [IDX_W:0] mod_step(input logic [IDX_W:0] rem,
                                               input logic          din,
                                               input logic [IDX_W:0] dvs);
    logic [IDX_W:0] s;
    s = {rem[IDX_W-1:0], din};
    if (s >= dvs) s = s - dvs;
    return s;
  endfunction

  assign accept   = req_valid && req_ready;
  assign mod_last = (mod_cnt == CNT_W'(RND_W - 1));
  assign push     = (state == S_RESP) && rsp_ready && !rsp_empty;
  assign rem_next = mod_step(rem_p1, rnd_p0[RND_W-1], rsp_count);

  // Eligibility from live inputs and the history; captured only at accept.
  always_comb begin
    elig_c = '0;
    fb_c   = '0;
    for (int i = 0; i < BS; i++) begin
      fb_c[i]   = candidate_list[i] && (IDX_W'(i) != cur_index);
      elig_c[i] = fb_c[i];
      for (int k = 0; k < HIST; k++) begin
        if (hist_vld[k] && (hist_idx[k] == IDX_W'(i))) elig_c[i] = 1'b0;
      end
    end
  end

  // Compact the selected mask into the table in ascending slot order.
  always_comb begin
    load_mask = elig_p0;
`ifdef MAP_FALLBACK_EN
    if (elig_p0 == '0) load_mask = fb_p0;
`endif
    tbl_c    = '0;
    load_cnt = '0;
    for (int i = 0; i < BS; i++) begin
      if (load_mask[i]) begin
        tbl_c[load_cnt[IDX_W-1:0]] = IDX_W'(i);
        load_cnt = load_cnt + (IDX_W+1)'(1);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = S_LOAD;
      S_LOAD: state_nxt = (load_cnt == '0) ? S_RESP : S_MOD;
      S_MOD:  if (mod_last) state_nxt = S_RESP;
      S_RESP: if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    req_ready = (state == S_IDLE);
    rsp_valid = (state == S_RESP);
  end

  // Divider bit counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                mod_cnt <= '0;
    else if (state == S_LOAD) mod_cnt <= '0;
    else if (state == S_MOD)  mod_cnt <= mod_cnt + CNT_W'(1);
  end

  // Result registers; held unchanged through RESP until the handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_index <= '0;
      rsp_empty <= 1'b0;
      rsp_count <= '0;
    end else begin
      if (state == S_LOAD) begin
        rsp_count <= load_cnt;
        rsp_empty <= (load_cnt == '0);
        rsp_index <= '0;
      end else if ((state == S_MOD) && mod_last) begin
        rsp_index <= tbl_p1[rem_next[IDX_W-1:0]];
        rsp_empty <= 1'b0;
      end
    end
  end

  // History valid bits; clear wins over a same-edge push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_vld <= '0;
    end else if (hist_clear) begin
      hist_vld <= '0;
    end else if (push) begin
      hist_vld[0] <= 1'b1;
      for (int k = 1; k < HIST; k++) hist_vld[k] <= hist_vld[k-1];
    end
  end

  // History slot indices, newest in entry 0.
  always_ff @(posedge clk) begin
    if (push) begin
      hist_idx[0] <= rsp_index;
      for (int k = 1; k < HIST; k++) hist_idx[k] <= hist_idx[k-1];
    end
  end

  // ---- p0: capture at accept ----
  always_ff @(posedge clk) begin
    if (accept) begin
      elig_p0 <= elig_c;
      rnd_p0  <= random_number;
`ifdef MAP_FALLBACK_EN
      fb_p0   <= fb_c;
`endif
    end else if (state == S_MOD) begin
      rnd_p0  <= rnd_p0 << 1;
    end
  end

  // ---- p1: table load and serial remainder ----
  always_ff @(posedge clk) begin
    if (state == S_LOAD) begin
      tbl_p1 <= tbl_c;
      rem_p1 <= '0;
    end else if (state == S_MOD) begin
      rem_p1 <= rem_next;
    end
  end

endmodule

// File: tb/tb_candidate_mapper.sv
// Bench for candidate_mapper (BS=16, HIST=3, RND_W=6): directed scenarios
// followed by randomized transactions, checked against a list-based model.
module tb_candidate_mapper;

  localparam int BS    = 16;
  localparam int HIST  = 3;
  localparam int RND_W = 6;
  localparam int IDX_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [0:BS-1]    candidate_list;
  logic [IDX_W-1:0] cur_index;
  logic [RND_W-1:0] random_number;
  logic             hist_clear;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [IDX_W-1:0] rsp_index;
  logic             rsp_empty;
  logic [IDX_W:0]   rsp_count;

  int checks = 0;
  int errors = 0;
  int hist_q[$];

  candidate_mapper #(.BS(BS), .HIST(HIST), .RND_W(RND_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .candidate_list(candidate_list), .cur_index(cur_index),
    .random_number(random_number), .hist_clear(hist_clear),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_index(rsp_index), .rsp_empty(rsp_empty), .rsp_count(rsp_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit in_hist(input int s);
    foreach (hist_q[k]) if (hist_q[k] == s) return 1'b1;
    return 1'b0;
  endfunction

  // Reference: list eligible slots, pick list[rnd % n].
  function automatic void model(input logic [15:0] m, input int cur, input int rnd,
                                output int idx, output int cnt, output bit empty);
    int lst[$];
    for (int i = 0; i < BS; i++)
      if (m[i] && i != cur && !in_hist(i)) lst.push_back(i);
`ifdef MAP_FALLBACK_EN
    if (lst.size() == 0)
      for (int i = 0; i < BS; i++)
        if (m[i] && i != cur) lst.push_back(i);
`endif
    cnt = lst.size();
    if (cnt == 0) begin
      idx = 0; empty = 1'b1;
    end else begin
      idx = lst[rnd % cnt]; empty = 1'b0;
    end
  endfunction

  task automatic run_txn(input logic [15:0] m, input int cur, input int rnd,
                         input int stall, input bit clr_hs, input bit clr_mid,
                         input string tag);
    int e_idx, e_cnt, k;
    bit e_emp;
    model(m, cur, rnd, e_idx, e_cnt, e_emp);
    @(negedge clk);
    for (int i = 0; i < BS; i++) candidate_list[i] = m[i];
    cur_index     = IDX_W'(cur);
    random_number = RND_W'(rnd);
    req_valid     = 1'b1;
    chk({tag, "/req_ready"}, 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid  = 1'b0;
    hist_clear = clr_mid;
    if (clr_mid) hist_q.delete();
    k = 0;
    while (!rsp_valid && k < 4 * RND_W) begin
      @(negedge clk);
      hist_clear = 1'b0;
      k++;
    end
    hist_clear = 1'b0;
    chk({tag, "/latency"}, 32'(k), e_emp ? 32'd1 : 32'(RND_W + 1));
    chk({tag, "/index"}, 32'(rsp_index), 32'(e_idx));
    chk({tag, "/count"}, 32'(rsp_count), 32'(e_cnt));
    chk({tag, "/empty"}, 32'(rsp_empty), 32'(e_emp));
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk({tag, "/stall"}, {rsp_valid, req_ready, rsp_empty, rsp_count, rsp_index},
          {1'b1, 1'b0, e_emp, 5'(e_cnt), 4'(e_idx)});
    end
    rsp_ready  = 1'b1;
    hist_clear = clr_hs;
    @(negedge clk);
    rsp_ready  = 1'b0;
    hist_clear = 1'b0;
    chk({tag, "/after_hs"}, {rsp_valid, req_ready}, {1'b0, 1'b1});
    if (clr_hs) hist_q.delete();
    else if (!e_emp) begin
      hist_q.push_front(e_idx);
      if (hist_q.size() > HIST) void'(hist_q.pop_back());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "FAIL watchdog");
  end

  initial begin
    logic [15:0] m;
    rst = 1'b1; req_valid = 1'b0; candidate_list = '0; cur_index = '0;
    random_number = '0; hist_clear = 1'b0; rsp_ready = 1'b0;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {rsp_valid, req_ready, rsp_empty, rsp_count, rsp_index},
        {1'b1 ^ 1'b1, 1'b1, 1'b0, 5'd0, 4'd0});
    rst = 1'b1;
    hist_q.delete();

    // Test 1: basic pick, history empty.
    run_txn(16'h0228, 0, 7, 0, 0, 0, "t1");
    chk("t1_spec_index", 32'(rsp_index), 32'd5);
    // Tests 2 and 4: slot 5 now excluded; response stalled for five cycles.
    run_txn(16'h0228, 0, 7, 5, 0, 0, "t2");
    chk("t2_spec_index", 32'(rsp_index), 32'd9);
    // Test 3: all candidates in history.
    run_txn(16'h0220, 3, 7, 0, 0, 0, "t3");
`ifdef MAP_FALLBACK_EN
    chk("t3_spec_index", 32'(rsp_index), 32'd9);
`else
    chk("t3_spec_empty", {rsp_empty, rsp_index}, {1'b1, 4'd0});
`endif

    // Test 5: eviction of the oldest entry.
    @(negedge clk); hist_clear = 1'b1;
    @(negedge clk); hist_clear = 1'b0;
    hist_q.delete();
    for (int s = 1; s <= 4; s++) run_txn(16'(1 << s), 0, 0, 0, 0, 0, "t5_issue");
    run_txn(16'h0006, 0, 0, 0, 0, 0, "t5");
    chk("t5_spec", {rsp_count, rsp_index}, {5'd1, 4'd1});

    // Test 6: reset during MOD cycle 3 abandons the transaction.
    @(negedge clk);
    candidate_list = '1; cur_index = '0; random_number = 6'd13; req_valid = 1'b1;
    @(negedge clk); req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_reset_mid", {rsp_valid, req_ready, rsp_empty, rsp_count, rsp_index},
        {1'b0, 1'b1, 1'b0, 5'd0, 4'd0});
    rst = 1'b1;
    hist_q.delete();
    run_txn(16'h001A, 0, 0, 0, 0, 0, "t6_hist_empty");
    chk("t6_spec_count", 32'(rsp_count), 32'd3);
    run_txn(16'h0010, 0, 0, 0, 1, 0, "t6_clr_hs");
    run_txn(16'h0010, 0, 0, 0, 0, 0, "t6_after_clr");
    chk("t6_spec_after_clr", {rsp_empty, rsp_count, rsp_index}, {1'b0, 5'd1, 4'd4});
    // Clear while a selection is in flight.
    run_txn(16'h0030, 0, 1, 0, 0, 1, "t6_clr_mid");

    // Randomized transactions.
    for (int n = 0; n < 60; n++) begin
      m = (n % 3 == 0) ? 16'($urandom & $urandom & $urandom) : 16'($urandom);
      run_txn(m, int'($urandom_range(0, BS - 1)), int'($urandom_range(0, 63)),
              int'($urandom_range(0, 2)), $urandom_range(0, 7) == 0,
              $urandom_range(0, 7) == 0, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
